// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared encodings and defaults for the multiply/divide unit
package mdu_pkg;

    localparam int CNT_W = 4;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;
    localparam logic [2:0] MD_MADD  = 3'd7;

endpackage

// File: rtl/mdu_core.sv
// rtl/mdu_core.sv - combinational mult/div/madd result generator; madd under MDU_MADD_EN
module mdu_core
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [63:0] acc,
    output logic [63:0] result,
    output logic        valid
);

    logic [63:0] sprod;
    logic [63:0] uprod;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] uq;
    logic [31:0] ur;
    logic        is_signed_div;

    assign sprod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign uprod = {32'd0, a} * {32'd0, b};

    // Signed divide goes through magnitudes so INT_MIN / -1 never reaches a signed divider
    assign is_signed_div = (op == MD_DIV);
    assign mag_a = a[31] ? (32'd0 - a) : a;
    assign mag_b = b[31] ? (32'd0 - b) : b;
    assign dvd   = is_signed_div ? mag_a : a;
    assign dvs   = (b == 32'd0) ? 32'd1 : (is_signed_div ? mag_b : b);
    assign uq    = dvd / dvs;
    assign ur    = dvd % dvs;

`ifndef MDU_MADD_EN
    logic unused_acc;
    assign unused_acc = ^acc;
`endif

    always_comb begin
        result = 64'd0;
        valid  = 1'b1;
        case (op)
            MD_MULT:  result = sprod;
            MD_MULTU: result = uprod;
            MD_DIV: begin
                result[31:0]  = (a[31] ^ b[31]) ? (32'd0 - uq) : uq;
                result[63:32] = a[31] ? (32'd0 - ur) : ur;
                valid         = (b != 32'd0);
            end
            MD_DIVU: begin
                result = {ur, uq};
                valid  = (b != 32'd0);
            end
`ifdef MDU_MADD_EN
            MD_MADD:  result = acc + sprod;
`endif
            default:  result = 64'd0;
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// rtl/mdu_unit.sv - multi-cycle multiply/divide unit owning HI/LO; MDU_MADD_EN enables madd on MDOp 7
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Cancel,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    logic [CNT_W-1:0] cnt;
    logic [31:0]      pend_hi;
    logic [31:0]      pend_lo;
    logic             pend_ok;
    logic             last;
    logic             is_mul;
    logic             is_div;
    logic             accept;
    logic [63:0]      acc;
    logic [63:0]      core_result;
    logic             core_valid;

    assign last   = Busy && (cnt == CNT_W'(1));
`ifdef MDU_MADD_EN
    assign is_mul = (MDOp == MD_MULT) || (MDOp == MD_MULTU) || (MDOp == MD_MADD);
`else
    assign is_mul = (MDOp == MD_MULT) || (MDOp == MD_MULTU);
`endif
    assign is_div = (MDOp == MD_DIV) || (MDOp == MD_DIVU);

    // A start on the final busy edge chains directly behind the committing result
    assign accept = Start && !Cancel && (!Busy || last) && (is_mul || is_div);

    // madd chained behind a commit must accumulate onto the value being committed
    assign acc = (last && pend_ok) ? {pend_hi, pend_lo} : {HI, LO};

    mdu_core u_core (
        .op     (MDOp),
        .a      (A),
        .b      (B),
        .acc    (acc),
        .result (core_result),
        .valid  (core_valid)
    );

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            Busy    <= 1'b0;
            HI      <= 32'd0;
            LO      <= 32'd0;
            cnt     <= '0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_ok <= 1'b0;
        end else begin
            if (last) begin
                if (pend_ok) begin
                    HI <= pend_hi;
                    LO <= pend_lo;
                end
                Busy <= 1'b0;
                cnt  <= '0;
            end else if (Busy) begin
                cnt <= cnt - 1'b1;
            end

            if (!Busy && !Cancel) begin
                if (MDOp == MD_MTHI) HI <= A;
                if (MDOp == MD_MTLO) LO <= A;
            end

            if (accept) begin
                Busy    <= 1'b1;
                cnt     <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                pend_hi <= core_result[63:32];
                pend_lo <= core_result[31:0];
                pend_ok <= core_valid;
            end
        end
    end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage; consumes the decoded operands and control latched by the ID/EX pipeline register.
- Owns the architectural HI/LO registers.
- Returns Busy toward the hazard unit, which combines Start|Busy to stall ID and drive NOP_CLR into ID/EX.
- Handles mult, multu, div, divu, mthi and mtlo.

Parameters:
- MULT_CYCLES, 5: Busy duration for mult/multu; legal range 1..15.
- DIV_CYCLES, 10: Busy duration for div/divu; legal range 1..15.

Ports:
- CLK  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low (asserted when 0).
- Start  input  1  one-cycle request to begin mult/multu/div/divu; qualified by MDOp.
- MDOp  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved.
- A  input  32  rs operand (forwarded V1).
- B  input  32  rt operand (forwarded V2).
- Cancel  input  1  exception/interrupt in EX this cycle; suppresses any Start or mthi/mtlo sampled on the same edge.
- Busy  output  1  operation in flight.
- HI  output  32  architectural HI.
- LO  output  32  architectural LO.

Behaviour:
- Reset (reset=0, async): Busy=0, HI=0, LO=0, cycle counter=0, pending result regs=0. Reset mid-operation aborts the operation; no commit follows reset release.
- Idle, Start=1, Cancel=0, MDOp in {1..4} at edge E0:
  - Operands are captured and the full result is computed into pending regs.
  - The counter loads N (MULT_CYCLES or DIV_CYCLES); Busy=1 from E0.
  - The counter decrements on each edge. At edge E0+N, HI/LO take the pending values and Busy falls on that same edge.
  - Busy is therefore high for exactly N cycles.
  - Start in the same cycle Busy falls is legal and restarts back-to-back.
- Arithmetic:
  - mult: 64-bit signed product, {HI,LO}.
  - multu: 64-bit unsigned product, {HI,LO}.
  - div: LO = signed quotient truncated toward zero; HI = remainder, which takes the sign of the dividend.
  - divu: unsigned quotient and remainder.
- Divide by zero: the full DIV_CYCLES busy period elapses; HI and LO keep their prior values. No exception is raised.
- mthi/mtlo (MDOp 5/6, sampled when Start=1 or independently of Start):
  - Writes A to HI or LO at the next edge; Busy is not asserted.
  - Legal only when Busy=0.
  - If issued while Busy=1, it is ignored and the in-flight result later overwrites both HI and LO.
- Start while Busy=1: ignored, and the in-flight operation is unaffected. The hazard unit must prevent this case.
- Cancel=1 on the Start edge: no operation starts and HI/LO are unchanged. Cancel while Busy does not abort; the result still commits.
- MDOp 0/7 with Start=1: no effect.
- HI/LO are read combinationally by mfhi/mflo in EX. While Busy=1 they show the old values; stalling those reads is the hazard unit's responsibility.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: MDOp 7 becomes madd, signed {HI,LO} += A*B, with MULT_CYCLES latency and commit rules identical to mult. MDOp input stays 3 bits; maddu/msub are not supported.
- Undefined: MDOp 7 is reserved and ignored.

Decomposition:
- Shared package mdu_pkg holds:
  - MDOp encoding constants MD_NONE..MD_MADD.
  - Default cycle counts.
  - Counter width constant CNT_W=4.
- One natural sub-module, mdu_core: a combinational result generator (mult/div/madd from A, B, HI, LO, op → 64-bit pending value).
- mdu_unit keeps the counter, Busy and HI/LO registers.

Test Plan:
- Reset released; mult A=0xFFFFFFFF (-1), B=2 → Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- multu A=0xFFFFFFFF, B=2 → HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
- div A=-7 (0xFFFFFFF9), B=2 → after 10 cycles LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). divu A=7, B=0 → HI/LO keep prior values and Busy still lasts 10 cycles.
- mthi A=0x12345678 with Busy=0 → HI=0x12345678 next edge, Busy stays 0. Start+Cancel on mult → no Busy, HI/LO unchanged.
- reset driven 0 at cycle 3 of a div → HI=LO=0 and Busy=0 immediately (async); no commit after release.
- Back-to-back: a second mult Start on the cycle Busy falls → first result visible, second Busy period begins without a gap. With MDU_MADD_EN, HI=0, LO=5, madd A=3, B=4 → LO=17 after 5 cycles.
